wb_write_queue: RTL and testbench

- Write-back side initiator for the 32x32 register file's single write port (we/waddr/wdata).
- Collects register results from two producers: in0 is the main pipeline write-back, in1 is a multicycle unit such as a divider or load return.
- Queues them in a small FIFO and issues at most one register write per cycle, in arrival order.
- Exposes two lookup ports so the decode stage can detect, and take forwarded data from, writes still pending in the queue.

---
 rtl/wb_write_queue_if.sv | 46 ++++
 rtl/wb_write_queue.sv | 96 +++++++++
 tb/tb_wb_write_queue.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_queue_if.sv
// Bundle of producer handshakes, register-file write port and decode lookup ports
// for the write-back queue.
interface wb_write_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 3
);
  logic          in0_valid;
  logic          in0_ready;
  logic [AW-1:0] in0_addr;
  logic [DW-1:0] in0_data;
  logic          in1_valid;
  logic          in1_ready;
  logic [AW-1:0] in1_addr;
  logic [DW-1:0] in1_data;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] chk_addr1;
  logic          chk_hit1;
  logic [DW-1:0] chk_data1;
  logic [AW-1:0] chk_addr2;
  logic          chk_hit2;
  logic [DW-1:0] chk_data2;
  logic [CW-1:0] count;

  modport slave (
    input  in0_valid, in0_addr, in0_data,
    input  in1_valid, in1_addr, in1_data,
    input  chk_addr1, chk_addr2,
    output in0_ready, in1_ready,
    output we, waddr, wdata,
    output chk_hit1, chk_data1, chk_hit2, chk_data2,
    output count
  );

  modport master (
    output in0_valid, in0_addr, in0_data,
    output in1_valid, in1_addr, in1_data,
    output chk_addr1, chk_addr2,
    input  in0_ready, in1_ready,
    input  we, waddr, wdata,
    input  chk_hit1, chk_data1, chk_hit2, chk_data2,
    input  count
  );
endinterface

// File: rtl/wb_write_queue.sv
// Write-back queue: merges two result producers into one register-file write per cycle,
// in arrival order, with lookup ports for forwarding pending writes to decode.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int CW    = 3
) (
  input  logic            clk,
  input  logic            rst,
  wb_write_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic          acc0, acc1;
  logic          en0, en1;
  logic          deq;
  logic [PW-1:0] pos1;

  // Ready looks only at registered occupancy; a same-cycle pop earns no credit.
  always_comb begin
    bus.in0_ready = (count_q != CW'(DEPTH));
    if (bus.in0_valid) bus.in1_ready = (count_q <= CW'(DEPTH - 2));
    else               bus.in1_ready = (count_q != CW'(DEPTH));
  end

  always_comb begin
    acc0    = bus.in0_valid & bus.in0_ready;
    acc1    = bus.in1_valid & bus.in1_ready;
    // Writes to $0 finish the handshake but never occupy a slot.
    en0     = acc0 & (bus.in0_addr != '0);
    en1     = acc1 & (bus.in1_addr != '0);
    deq     = (count_q != '0);
    pos1    = en0 ? tail_q + PW'(1) : tail_q;
    head_d  = deq ? head_q + PW'(1) : head_q;
    tail_d  = tail_q + PW'(en0) + PW'(en1);
    count_d = count_q + CW'(en0) + CW'(en1) - CW'(deq);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en0) begin
      addr_q[tail_q] <= bus.in0_addr;
      data_q[tail_q] <= bus.in0_data;
    end
    if (en1) begin
      addr_q[pos1] <= bus.in1_addr;
      data_q[pos1] <= bus.in1_data;
    end
  end

  assign bus.we    = (count_q != '0);
  assign bus.waddr = bus.we ? addr_q[head_q] : '0;
  assign bus.wdata = bus.we ? data_q[head_q] : '0;
  assign bus.count = count_q;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx           = '0;
    bus.chk_hit1  = 1'b0;
    bus.chk_data1 = '0;
    bus.chk_hit2  = 1'b0;
    bus.chk_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((bus.chk_addr1 != '0) && (addr_q[idx] == bus.chk_addr1)) begin
          bus.chk_hit1  = 1'b1;
          bus.chk_data1 = data_q[idx];
        end
        if ((bus.chk_addr2 != '0) && (addr_q[idx] == bus.chk_addr2)) begin
          bus.chk_hit2  = 1'b1;
          bus.chk_data2 = data_q[idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: single/dual writes, $0 drop, youngest lookup,
// steady backpressure with continuous drain, and asynchronous reset mid-drain.
module tb_wb_write_queue;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   k;

  int exp_r1   [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
  int exp_cnt  [8] = '{0, 2, 3, 3, 3, 3, 3, 3};
  int exp_head [8] = '{0, 1, 20, 2, 21, 3, 4, 5};

  wb_write_queue_if #(.AW(5), .DW(32), .CW(3)) bus ();

  wb_write_queue #(.DEPTH(4), .AW(5), .DW(32), .CW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dval(input int a);
    if (a == 0)       return 32'h0;
    else if (a >= 20) return 32'hE000_0000 | 32'(a);
    else              return 32'hD000_0000 | 32'(a);
  endfunction

  task automatic idle();
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    k     = 0;
    rst           = 1'b0;
    bus.in0_valid = 1'b0;
    bus.in0_addr  = '0;
    bus.in0_data  = '0;
    bus.in1_valid = 1'b0;
    bus.in1_addr  = '0;
    bus.in1_data  = '0;
    bus.chk_addr1 = '0;
    bus.chk_addr2 = '0;

    // reset state
    #3;
    check("rst_we",    32'(bus.we),        32'd0);
    check("rst_waddr", 32'(bus.waddr),     32'd0);
    check("rst_wdata", bus.wdata,          32'd0);
    check("rst_count", 32'(bus.count),     32'd0);
    check("rst_rdy0",  32'(bus.in0_ready), 32'd1);
    check("rst_rdy1",  32'(bus.in1_ready), 32'd1);
    check("rst_hit1",  32'(bus.chk_hit1),  32'd0);
    check("rst_hit2",  32'(bus.chk_hit2),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();

    // single write into empty queue
    bus.in0_valid = 1'b1;
    bus.in0_addr  = 5'd3;
    bus.in0_data  = 32'h0000_ABCD;
    step();
    idle();
    check("single_we",    32'(bus.we),    32'd1);
    check("single_waddr", 32'(bus.waddr), 32'd3);
    check("single_wdata", bus.wdata,      32'h0000_ABCD);
    check("single_count", 32'(bus.count), 32'd1);
    step();
    check("single_we_after",    32'(bus.we),    32'd0);
    check("single_count_after", 32'(bus.count), 32'd0);
    check("single_waddr_after", 32'(bus.waddr), 32'd0);

    // dual enqueue, in0 ahead of in1
    bus.in0_valid = 1'b1;
    bus.in0_addr  = 5'd5;
    bus.in0_data  = 32'h11;
    bus.in1_valid = 1'b1;
    bus.in1_addr  = 5'd6;
    bus.in1_data  = 32'h22;
    #1;
    check("dual_rdy1", 32'(bus.in1_ready), 32'd1);
    step();
    idle();
    check("dual_count0", 32'(bus.count), 32'd2);
    check("dual_waddr0", 32'(bus.waddr), 32'd5);
    check("dual_wdata0", bus.wdata,      32'h11);
    step();
    check("dual_count1", 32'(bus.count), 32'd1);
    check("dual_waddr1", 32'(bus.waddr), 32'd6);
    check("dual_wdata1", bus.wdata,      32'h22);
    step();
    check("dual_count2", 32'(bus.count), 32'd0);
    check("dual_we2",    32'(bus.we),    32'd0);

    // write to $0 is dropped
    bus.in0_valid = 1'b1;
    bus.in0_addr  = 5'd0;
    bus.in0_data  = 32'hFFFF_FFFF;
    #1;
    check("zero_rdy0", 32'(bus.in0_ready), 32'd1);
    step();
    idle();
    check("zero_count", 32'(bus.count), 32'd0);
    check("zero_we",    32'(bus.we),    32'd0);

    // youngest match wins; lookup ignores same-cycle inputs
    bus.chk_addr1 = 5'd7;
    bus.chk_addr2 = 5'd9;
    bus.in0_valid = 1'b1;
    bus.in0_addr  = 5'd7;
    bus.in0_data  = 32'hA;
    bus.in1_valid = 1'b1;
    bus.in1_addr  = 5'd7;
    bus.in1_data  = 32'hB;
    #1;
    check("look_hit1_pre", 32'(bus.chk_hit1), 32'd0);
    step();
    idle();
    check("look_count", 32'(bus.count),     32'd2);
    check("look_hit1",  32'(bus.chk_hit1),  32'd1);
    check("look_data1", bus.chk_data1,      32'hB);
    check("look_hit2",  32'(bus.chk_hit2),  32'd0);
    check("look_data2", bus.chk_data2,      32'h0);
    check("look_wdata", bus.wdata,          32'hA);
    step();
    check("look_hit1_b",  32'(bus.chk_hit1), 32'd1);
    check("look_data1_b", bus.chk_data1,     32'hB);
    step();
    check("look_hit1_c",  32'(bus.chk_hit1), 32'd0);
    check("look_data1_c", bus.chk_data1,     32'h0);
    bus.chk_addr1 = '0;
    bus.chk_addr2 = '0;

    // sustained dual offer: in1 starves once free < 2, drain keeps count at 3
    for (int c = 0; c < 8; c++) begin
      bus.in0_valid = 1'b1;
      bus.in0_addr  = 5'(c + 1);
      bus.in0_data  = dval(c + 1);
      bus.in1_valid = 1'b1;
      bus.in1_addr  = 5'(20 + k);
      bus.in1_data  = dval(20 + k);
      #1;
      check($sformatf("fill_rdy0_%0d", c),  32'(bus.in0_ready), 32'd1);
      check($sformatf("fill_rdy1_%0d", c),  32'(bus.in1_ready), 32'(exp_r1[c]));
      check($sformatf("fill_count_%0d", c), 32'(bus.count),     32'(exp_cnt[c]));
      check($sformatf("fill_waddr_%0d", c), 32'(bus.waddr),     32'(exp_head[c]));
      check($sformatf("fill_wdata_%0d", c), bus.wdata,          dval(exp_head[c]));
      if (exp_r1[c] != 0) k++;
      step();
    end
    idle();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("drain_count_%0d", c), 32'(bus.count), 32'(3 - c));
      check($sformatf("drain_waddr_%0d", c), 32'(bus.waddr), 32'(6 + c));
      check($sformatf("drain_wdata_%0d", c), bus.wdata,      dval(6 + c));
      step();
    end
    check("drain_empty", 32'(bus.count), 32'd0);
    check("drain_we",    32'(bus.we),    32'd0);

    // asynchronous reset with three pending writes
    bus.in0_valid = 1'b1;
    bus.in0_addr  = 5'd10;
    bus.in0_data  = 32'h100;
    bus.in1_valid = 1'b1;
    bus.in1_addr  = 5'd11;
    bus.in1_data  = 32'h110;
    step();
    bus.in0_addr  = 5'd12;
    bus.in0_data  = 32'h120;
    bus.in1_addr  = 5'd13;
    bus.in1_data  = 32'h130;
    step();
    idle();
    bus.chk_addr1 = 5'd12;
    bus.chk_addr2 = 5'd13;
    #1;
    check("mid_count", 32'(bus.count),    32'd3);
    check("mid_hit1",  32'(bus.chk_hit1), 32'd1);
    check("mid_waddr", 32'(bus.waddr),    32'd11);
    rst = 1'b0;
    #1;
    check("arst_we",    32'(bus.we),       32'd0);
    check("arst_count", 32'(bus.count),    32'd0);
    check("arst_hit1",  32'(bus.chk_hit1), 32'd0);
    check("arst_hit2",  32'(bus.chk_hit2), 32'd0);
    check("arst_data1", bus.chk_data1,     32'h0);
    check("arst_waddr", 32'(bus.waddr),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.chk_addr1 = 5'd9;
    bus.in0_valid = 1'b1;
    bus.in0_addr  = 5'd9;
    bus.in0_data  = 32'h99;
    step();
    idle();
    check("post_we",    32'(bus.we),       32'd1);
    check("post_waddr", 32'(bus.waddr),    32'd9);
    check("post_wdata", bus.wdata,         32'h99);
    check("post_count", 32'(bus.count),    32'd1);
    check("post_hit1",  32'(bus.chk_hit1), 32'd1);
    check("post_data1", bus.chk_data1,     32'h99);
    step();
    check("post_empty", 32'(bus.count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
